// File: rtl/execute_branch_xlen_if.sv
// rtl/execute_branch_xlen_if.sv - decode/operand request and result bundle for execute_branch_xlen
//
// Parameter: XLEN - datapath width (32 or 64).
// master: decode/register-read side drives decode_*, read_*, result_ready; observes results.
// slave : branch unit; observes requests, drives processing, valid, pc_out, jump_pc,
//         rd_val_out, rd_write, exception_num_out, exception_valid_out.
interface execute_branch_xlen_if #(
    parameter int XLEN = 32
);
    logic [6:0]      decode_opcode;
    logic [2:0]      decode_funct3;
    logic [XLEN-1:0] decode_imm;
    logic [XLEN-1:0] decode_pc;
    logic [XLEN-1:0] read_rs1_val;
    logic [XLEN-1:0] read_rs2_val;
    logic            read_valid;
    logic            result_ready;

    logic            processing;
    logic            valid;
    logic [XLEN-1:0] pc_out;
    logic            jump_pc;
    logic [XLEN-1:0] rd_val_out;
    logic            rd_write;
    logic [5:0]      exception_num_out;
    logic            exception_valid_out;

    modport master (
        output decode_opcode, decode_funct3, decode_imm, decode_pc,
               read_rs1_val, read_rs2_val, read_valid, result_ready,
        input  processing, valid, pc_out, jump_pc, rd_val_out, rd_write,
               exception_num_out, exception_valid_out
    );

    modport slave (
        input  decode_opcode, decode_funct3, decode_imm, decode_pc,
               read_rs1_val, read_rs2_val, read_valid, result_ready,
        output processing, valid, pc_out, jump_pc, rd_val_out, rd_write,
               exception_num_out, exception_valid_out
    );
endinterface

// File: rtl/execute_branch_xlen.sv
// rtl/execute_branch_xlen.sv - XLEN branch/JAL/JALR execution unit with IDLE/EXEC/DONE pipeline
//
// Ports:
//   i_clk   - clock, rising edge
//   i_reset - asynchronous active-low reset
//   i_flush - synchronous flush, returns to IDLE and clears all outputs
//   bus     - execute_branch_xlen_if.slave (decode/operand request, result handshake)
// Optional feature macro: BRANCH_COMPRESSED_EN (2-byte target alignment instead of 4-byte).
module execute_branch_xlen #(
    parameter int         XLEN           = 32,
    parameter logic [5:0] EXC_MISALIGNED = 6'd0,
    parameter logic [5:0] EXC_ILLEGAL    = 6'd2
) (
    input logic                  i_clk,
    input logic                  i_reset,
    input logic                  i_flush,
    execute_branch_xlen_if.slave bus
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [6:0]      r_opcode;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;

    logic            r_processing;
    logic            r_valid;
    logic [XLEN-1:0] r_pc_out;
    logic            r_jump_pc;
    logic [XLEN-1:0] r_rd_val;
    logic            r_rd_write;
    logic [5:0]      r_exc_num;
    logic            r_exc_valid;

    logic            w_accept_op;
    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_cond;
    logic            w_illegal;
    logic            w_taken;
    logic            w_misaligned;
    logic [XLEN-1:0] w_sum_pc;
    logic [XLEN-1:0] w_sum_rs1;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_link;

    assign w_accept_op = (bus.decode_opcode == OP_BRANCH) ||
                         (bus.decode_opcode == OP_JAL)    ||
                         (bus.decode_opcode == OP_JALR);

    // Everything below works only on the captured copies so that decode/read
    // inputs may change freely once the request has been accepted.
    always_comb begin
        w_is_branch = (r_opcode == OP_BRANCH);
        w_is_jal    = (r_opcode == OP_JAL);
        w_is_jalr   = (r_opcode == OP_JALR);

        w_cond = 1'b0;
        case (r_funct3)
            3'b000:  w_cond = (r_rs1 == r_rs2);
            3'b001:  w_cond = (r_rs1 != r_rs2);
            3'b100:  w_cond = ($signed(r_rs1) <  $signed(r_rs2));
            3'b101:  w_cond = ($signed(r_rs1) >= $signed(r_rs2));
            3'b110:  w_cond = (r_rs1 <  r_rs2);
            3'b111:  w_cond = (r_rs1 >= r_rs2);
            default: w_cond = 1'b0;
        endcase

        w_illegal = w_is_branch && (r_funct3[2:1] == 2'b01);
        w_taken   = w_is_jal || w_is_jalr || (w_is_branch && w_cond && !w_illegal);

        w_sum_pc  = r_pc + r_imm;
        w_sum_rs1 = r_rs1 + r_imm;
        // JALR drops bit 0 of the computed address before the alignment check.
        w_target  = w_is_jalr ? (w_sum_rs1 & ~{{(XLEN-1){1'b0}}, 1'b1}) : w_sum_pc;
        w_link    = r_pc + XLEN'(4);

`ifdef BRANCH_COMPRESSED_EN
        w_misaligned = w_target[0];
`else
        w_misaligned = (w_target[1:0] != 2'b00);
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_opcode     <= '0;
            r_funct3     <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_processing <= 1'b0;
            r_valid      <= 1'b0;
            r_pc_out     <= '0;
            r_jump_pc    <= 1'b0;
            r_rd_val     <= '0;
            r_rd_write   <= 1'b0;
            r_exc_num    <= '0;
            r_exc_valid  <= 1'b0;
        end else if (i_flush) begin
            // Flush wins over both a new accept and a result handshake.
            r_state      <= S_IDLE;
            r_processing <= 1'b0;
            r_valid      <= 1'b0;
            r_pc_out     <= '0;
            r_jump_pc    <= 1'b0;
            r_rd_val     <= '0;
            r_rd_write   <= 1'b0;
            r_exc_num    <= '0;
            r_exc_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.read_valid && w_accept_op) begin
                        r_opcode     <= bus.decode_opcode;
                        r_funct3     <= bus.decode_funct3;
                        r_imm        <= bus.decode_imm;
                        r_pc         <= bus.decode_pc;
                        r_rs1        <= bus.read_rs1_val;
                        r_rs2        <= bus.read_rs2_val;
                        r_processing <= 1'b1;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_valid  <= 1'b1;
                    r_rd_val <= w_link;
                    if (w_illegal) begin
                        r_pc_out    <= w_link;
                        r_jump_pc   <= 1'b0;
                        r_rd_write  <= 1'b0;
                        r_exc_num   <= EXC_ILLEGAL;
                        r_exc_valid <= 1'b1;
                    end else if (w_taken && w_misaligned) begin
                        r_pc_out    <= w_target;
                        r_jump_pc   <= 1'b0;
                        r_rd_write  <= 1'b0;
                        r_exc_num   <= EXC_MISALIGNED;
                        r_exc_valid <= 1'b1;
                    end else if (w_taken) begin
                        r_pc_out    <= w_target;
                        r_jump_pc   <= 1'b1;
                        r_rd_write  <= w_is_jal || w_is_jalr;
                        r_exc_num   <= '0;
                        r_exc_valid <= 1'b0;
                    end else begin
                        r_pc_out    <= w_link;
                        r_jump_pc   <= 1'b0;
                        r_rd_write  <= 1'b0;
                        r_exc_num   <= '0;
                        r_exc_valid <= 1'b0;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // Outputs are cleared on hand-off so nothing stale is visible while idle.
                    if (bus.result_ready) begin
                        r_processing <= 1'b0;
                        r_valid      <= 1'b0;
                        r_pc_out     <= '0;
                        r_jump_pc    <= 1'b0;
                        r_rd_val     <= '0;
                        r_rd_write   <= 1'b0;
                        r_exc_num    <= '0;
                        r_exc_valid  <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.processing          = r_processing;
    assign bus.valid               = r_valid;
    assign bus.pc_out              = r_pc_out;
    assign bus.jump_pc             = r_jump_pc;
    assign bus.rd_val_out          = r_rd_val;
    assign bus.rd_write            = r_rd_write;
    assign bus.exception_num_out   = r_exc_num;
    assign bus.exception_valid_out = r_exc_valid;
endmodule

// File: tb/tb_execute_branch_xlen.sv
// tb/tb_execute_branch_xlen.sv - self-checking bench for execute_branch_xlen (XLEN 32 and 64)
module tb_execute_branch_xlen;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] e_pc;
        logic        e_jump;
        logic [31:0] e_rd;
        logic        e_rdw;
        logic        e_exc;
        logic [5:0]  e_num;
        logic        chk_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[15];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    execute_branch_xlen_if #(.XLEN(32)) if32 ();
    execute_branch_xlen_if #(.XLEN(64)) if64 ();

    execute_branch_xlen #(.XLEN(32)) dut32 (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush), .bus(if32)
    );
    execute_branch_xlen #(.XLEN(64)) dut64 (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush), .bus(if64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] e_pc, input logic e_jump,
                                input logic e_rdw, input logic e_exc,
                                input logic [5:0] e_num, input logic chk_pc);
        vec_t v;
        v.op = op; v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
        v.e_pc = e_pc; v.e_jump = e_jump; v.e_rd = pc + 32'd4; v.e_rdw = e_rdw;
        v.e_exc = e_exc; v.e_num = e_num; v.chk_pc = chk_pc;
        return v;
    endfunction

    task automatic check_idle32(input string nm);
        chk({nm, " valid"}, 64'(if32.valid), 64'd0);
        chk({nm, " processing"}, 64'(if32.processing), 64'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        vec_t e;
        int   lat;
        v = vecs[idx];
        @(negedge clk);
        if32.decode_opcode = v.op;
        if32.decode_funct3 = v.f3;
        if32.decode_pc     = v.pc;
        if32.decode_imm    = v.imm;
        if32.read_rs1_val  = v.rs1;
        if32.read_rs2_val  = v.rs2;
        if32.read_valid    = 1'b1;
        if32.result_ready  = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after the accept edge; the result must not move.
        if32.read_valid   = 1'b0;
        if32.decode_pc    = $urandom;
        if32.decode_imm   = $urandom;
        if32.read_rs1_val = $urandom;
        if32.read_rs2_val = $urandom;
        if32.decode_funct3 = 3'($urandom);
        chk($sformatf("v%0d processing", idx), 64'(if32.processing), 64'd1);
        chk($sformatf("v%0d early valid", idx), 64'(if32.valid), 64'd0);
        lat = 1;
        while (!if32.valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 64'(lat), 64'd2);
        if (if32.valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_pc) chk($sformatf("v%0d pc_out", idx), 64'(if32.pc_out), 64'(e.e_pc));
            chk($sformatf("v%0d jump_pc", idx), 64'(if32.jump_pc), 64'(e.e_jump));
            chk($sformatf("v%0d rd_val", idx), 64'(if32.rd_val_out), 64'(e.e_rd));
            chk($sformatf("v%0d rd_write", idx), 64'(if32.rd_write), 64'(e.e_rdw));
            chk($sformatf("v%0d exc_valid", idx), 64'(if32.exception_valid_out), 64'(e.e_exc));
            chk($sformatf("v%0d exc_num", idx), 64'(if32.exception_num_out), 64'(e.e_num));
        end else begin
            exp_q.delete();
        end
        @(negedge clk);
        check_idle32($sformatf("v%0d after ready", idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected results are hand-derived constants.
        vecs[0]  = mk(OP_BRANCH, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 32'h120, 1, 0, 0, 6'd0, 1);
        vecs[1]  = mk(OP_BRANCH, 3'b100, 32'h100, 32'h40, 32'hFFFFFFFF, 32'd1, 32'h140, 1, 0, 0, 6'd0, 1);
        vecs[2]  = mk(OP_BRANCH, 3'b110, 32'h100, 32'h40, 32'hFFFFFFFF, 32'd1, 32'h104, 0, 0, 0, 6'd0, 1);
        vecs[3]  = mk(OP_BRANCH, 3'b001, 32'h300, 32'h10, 32'd7, 32'd7, 32'h304, 0, 0, 0, 6'd0, 1);
        vecs[4]  = mk(OP_BRANCH, 3'b001, 32'h300, 32'h10, 32'd7, 32'd8, 32'h310, 1, 0, 0, 6'd0, 1);
        vecs[5]  = mk(OP_BRANCH, 3'b101, 32'h400, 32'hFFFFFFF8, 32'd1, 32'hFFFFFFFF, 32'h3F8, 1, 0, 0, 6'd0, 1);
        vecs[6]  = mk(OP_BRANCH, 3'b111, 32'h400, 32'hFFFFFFF8, 32'd1, 32'hFFFFFFFF, 32'h404, 0, 0, 0, 6'd0, 1);
`ifdef BRANCH_COMPRESSED_EN
        vecs[7]  = mk(OP_BRANCH, 3'b000, 32'h500, 32'h6, 32'd0, 32'd0, 32'h506, 1, 0, 0, 6'd0, 1);
        vecs[10] = mk(OP_JALR, 3'b000, 32'h200, 32'h2, 32'h1001, 32'd0, 32'h1002, 1, 1, 0, 6'd0, 1);
`else
        vecs[7]  = mk(OP_BRANCH, 3'b000, 32'h500, 32'h6, 32'd0, 32'd0, 32'h506, 0, 0, 1, 6'd0, 1);
        vecs[10] = mk(OP_JALR, 3'b000, 32'h200, 32'h2, 32'h1001, 32'd0, 32'h1002, 0, 0, 1, 6'd0, 1);
`endif
        vecs[8]  = mk(OP_BRANCH, 3'b000, 32'h500, 32'h6, 32'd1, 32'd0, 32'h504, 0, 0, 0, 6'd0, 1);
        vecs[9]  = mk(OP_JAL, 3'b000, 32'h1000, 32'h800, 32'd0, 32'd0, 32'h1800, 1, 1, 0, 6'd0, 1);
        vecs[11] = mk(OP_JALR, 3'b000, 32'h200, 32'h1, 32'h2003, 32'd0, 32'h2004, 1, 1, 0, 6'd0, 1);
        vecs[12] = mk(OP_BRANCH, 3'b011, 32'h800, 32'h10, 32'd0, 32'd0, 32'h0, 0, 0, 1, 6'd2, 0);
        vecs[13] = mk(OP_BRANCH, 3'b100, 32'h600, 32'h8, 32'd1, 32'hFFFFFFFF, 32'h604, 0, 0, 0, 6'd0, 1);
        vecs[14] = mk(OP_JAL, 3'b000, 32'h10, 32'hFFFFFFE0, 32'd0, 32'd0, 32'hFFFFFFF0, 1, 1, 0, 6'd0, 1);

        if32.decode_opcode = '0; if32.decode_funct3 = '0; if32.decode_imm = '0;
        if32.decode_pc = '0; if32.read_rs1_val = '0; if32.read_rs2_val = '0;
        if32.read_valid = 1'b0; if32.result_ready = 1'b0;
        if64.decode_opcode = '0; if64.decode_funct3 = '0; if64.decode_imm = '0;
        if64.decode_pc = '0; if64.read_rs1_val = '0; if64.read_rs2_val = '0;
        if64.read_valid = 1'b0; if64.result_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset valid", 64'(if32.valid), 64'd0);
        chk("reset processing", 64'(if32.processing), 64'd0);
        chk("reset pc_out", 64'(if32.pc_out), 64'd0);
        chk("reset rd_val", 64'(if32.rd_val_out), 64'd0);
        chk("reset jump/rdw/exc", {61'd0, if32.jump_pc, if32.rd_write, if32.exception_valid_out}, 64'd0);
        chk("reset exc_num", 64'(if32.exception_num_out), 64'd0);
        chk("reset64 pc_out", if64.pc_out, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i);

        // Unsupported opcode is ignored.
        @(negedge clk);
        if32.decode_opcode = 7'b0110011;
        if32.read_valid = 1'b1;
        @(negedge clk);
        if32.read_valid = 1'b0;
        check_idle32("bad opcode");

        // Illegal funct3 held while result_ready low, read_valid pulses ignored.
        @(negedge clk);
        if32.decode_opcode = OP_BRANCH; if32.decode_funct3 = 3'b010;
        if32.decode_pc = 32'h700; if32.decode_imm = 32'h10;
        if32.read_rs1_val = 32'd0; if32.read_rs2_val = 32'd0;
        if32.read_valid = 1'b1; if32.result_ready = 1'b0;
        @(negedge clk);
        if32.read_valid = 1'b0;
        if32.decode_opcode = OP_JAL; if32.decode_pc = 32'h900;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if32.read_valid = c[0];
            chk($sformatf("hold%0d valid", c), 64'(if32.valid), 64'd1);
            chk($sformatf("hold%0d exc_valid", c), 64'(if32.exception_valid_out), 64'd1);
            chk($sformatf("hold%0d exc_num", c), 64'(if32.exception_num_out), 64'd2);
            chk($sformatf("hold%0d jump/rdw", c), {62'd0, if32.jump_pc, if32.rd_write}, 64'd0);
            chk($sformatf("hold%0d rd_val", c), 64'(if32.rd_val_out), 64'h704);
        end
        if32.read_valid = 1'b0;
        if32.result_ready = 1'b1;
        @(negedge clk);
        check_idle32("hold release");
        repeat (3) @(negedge clk);
        check_idle32("hold pulses ignored");

        // Flush while in EXEC.
        @(negedge clk);
        if32.decode_opcode = OP_BRANCH; if32.decode_funct3 = 3'b000;
        if32.read_rs1_val = 32'd1; if32.read_rs2_val = 32'd1;
        if32.read_valid = 1'b1;
        @(negedge clk);
        if32.read_valid = 1'b0;
        flush = 1'b1;
        chk("flush exec processing", 64'(if32.processing), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        check_idle32("flush exec next");
        repeat (3) @(negedge clk);
        check_idle32("flush exec later");

        // Flush coincident with accept.
        @(negedge clk);
        if32.read_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        if32.read_valid = 1'b0;
        flush = 1'b0;
        check_idle32("flush accept");
        repeat (2) @(negedge clk);
        check_idle32("flush accept later");

        // XLEN=64 JAL wrap, then reset while in DONE.
        @(negedge clk);
        if64.decode_opcode = OP_JAL; if64.decode_funct3 = 3'b000;
        if64.decode_pc = 64'hFFFFFFFFFFFFFFF0; if64.decode_imm = 64'h20;
        if64.read_valid = 1'b1; if64.result_ready = 1'b0;
        @(negedge clk);
        if64.read_valid = 1'b0;
        @(negedge clk);
        chk("x64 valid", 64'(if64.valid), 64'd1);
        chk("x64 pc_out", if64.pc_out, 64'h10);
        chk("x64 rd_val", if64.rd_val_out, 64'hFFFFFFFFFFFFFFF4);
        chk("x64 jump/rdw", {62'd0, if64.jump_pc, if64.rd_write}, 64'd3);
        chk("x64 exc_valid", 64'(if64.exception_valid_out), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("x64 rst valid/proc", {62'd0, if64.valid, if64.processing}, 64'd0);
        chk("x64 rst pc_out", if64.pc_out, 64'd0);
        chk("x64 rst rd_val", if64.rd_val_out, 64'd0);
        chk("x64 rst jump/rdw", {62'd0, if64.jump_pc, if64.rd_write}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("x64 post reset valid", 64'(if64.valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_branch_xlen.md
# execute_branch_xlen

XLEN-parametrised branch/jump execution unit with its own comparator and target adder, a registered three-state pipeline, and a ready/valid result handshake. Resolves RV BRANCH, JAL and JALR: produces next PC, taken flag, link value and alignment/illegal-funct3 exceptions. Sits in the execute stage beside the ALU and load/store units, fed by decode and register read, drained by writeback/fetch redirect.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- EXC_MISALIGNED, 6'd0: exception number for a misaligned taken target.
- EXC_ILLEGAL, 6'd2: exception number for a BRANCH with funct3 010 or 011.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- decode_opcode  in  7  instruction opcode.
- decode_funct3  in  3  branch condition.
- decode_imm  in  XLEN  sign-extended immediate.
- decode_pc  in  XLEN  instruction PC.
- read_rs1_val, read_rs2_val  in  XLEN  operands.
- read_valid  in  1  operands and decode fields valid this cycle.
- result_ready  in  1  consumer accepts the result.
- processing  out  1  unit busy (EXEC or DONE).
- valid  out  1  result outputs valid.
- pc_out  out  XLEN  next PC.
- jump_pc  out  1  redirect required (taken branch, JAL, JALR).
- rd_val_out  out  XLEN  link value pc+4.
- rd_write  out  1  rd_val_out must be written (JAL/JALR only).
- exception_num_out  out  6  exception cause.
- exception_valid_out  out  1  exception instead of result.

## Operation
- Opcodes: BRANCH 1100011, JAL 1101111, JALR 1100111. Any other opcode with read_valid is ignored; unit stays IDLE.
- States IDLE -> EXEC -> DONE -> IDLE.
- IDLE: on read_valid with accepted opcode and no flush, capture all decode/read inputs, go EXEC.
- EXEC: compute condition and target into registers, go DONE.
- DONE: valid=1, outputs stable; on result_ready go IDLE. New accepts only in IDLE.
- Conditions (funct3): 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; XLEN-bit compare. 010/011: exception_valid_out=1, exception_num_out=EXC_ILLEGAL, jump_pc=0, rd_write=0.
- Targets modulo 2^XLEN: BRANCH/JAL pc+imm; JALR (rs1+imm) with bit0 cleared. Not taken: pc_out=pc+4, jump_pc=0.
- Link: rd_val_out=pc+4 for all; rd_write=1 for JAL/JALR, 0 for BRANCH.
- Misalignment checked only when taken (see Configuration): exception_valid_out=1, EXC_MISALIGNED, jump_pc=0, rd_write=0, pc_out=offending target.
- Exception outputs only meaningful while valid=1; 0 otherwise.

## Timing
- Reset (reset=0, async): state IDLE; processing, valid, jump_pc, rd_write, exception_valid_out =0; pc_out, rd_val_out, exception_num_out =0.
- Latency: accept at edge N; processing=1 from N+1; valid=1 from N+2.
- valid held with stable outputs until the edge where result_ready=1; valid=0 and processing=0 the cycle after.
- Minimum 3 cycles between accepts.
- flush: any state -> IDLE at next edge; all outputs cleared; overrides accept and result_ready in same cycle.
- read_valid while not IDLE is ignored (no capture, no stall signalling beyond processing).
- Reset asserted mid-operation: immediate return to reset values, pending result discarded.
- Input changes after accept do not affect the result.

## Configuration
- BRANCH_COMPRESSED_EN defined: alignment 2 bytes; taken target misaligned iff bit0=1 (never for JALR).
- Undefined: alignment 4 bytes; misaligned iff target[1:0]!=00, including JALR after bit0 clear.

## Test plan
- XLEN=32, BEQ, pc=0x100, imm=0x20, rs1=rs2=5, result_ready=1 -> valid 2 cycles after accept, jump_pc=1, pc_out=0x120, rd_write=0.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, pc_out=pc+4.
- JALR pc=0x200, rs1=0x1001, imm=0x2 -> without macro: exception EXC_MISALIGNED, pc_out=0x1002; with BRANCH_COMPRESSED_EN: jump_pc=1, pc_out=0x1002, rd_val_out=0x204, rd_write=1.
- BRANCH funct3=010 -> exception_valid_out=1, exception_num_out=2; result_ready=0 for 5 cycles -> valid and outputs held, read_valid pulses ignored.
- flush in EXEC -> valid never asserts, processing=0 next cycle; flush coincident with accept in IDLE -> no capture.
- XLEN=64 JAL pc=0xFFFFFFFFFFFFFFF0, imm=0x20 -> pc_out=0x10 (wrap), rd_val_out=0xFFFFFFFFFFFFFFF4; reset asserted in DONE -> all outputs 0 immediately.
